spad_weight_pe: RTL and testbench
=================================

// Module: spad_weight_pe
// PURPOSE
//   Per-PE weight scratchpad, directly downstream of the GLB weight router.
//   - Captures one filter (kernel_size**2 words) streamed in on w_data_spad/load_en_spad.
//   - Tracks fill state.
//   - Serves the PE MAC datapath through a registered read port with 1-cycle latency.
//   - Flags writes that arrive after the pad is full.
// PARAMETERS
//   DATA_BITWIDTH      16  width of one weight word
//   ADDR_BITWIDTH_SPAD 9   read-address width; must satisfy 2**ADDR_BITWIDTH_SPAD >= kernel_size**2
//   kernel_size        3   filter side; pad depth = KK = kernel_size**2 (default 9)
// PORTS
//   clk            in  1     rising-edge clock
//   reset          in  1     asynchronous, active-high reset
//   w_data_spad    in  DATA_BITWIDTH  weight word from router, valid when load_en_spad=1
//   load_en_spad   in  1     write strobe; one word per high cycle
//   spad_clear     in  1     synchronous clear of fill state (start of next filter)
//   read_req_spad  in  1     read request from MAC
//   r_addr_spad    in  ADDR_BITWIDTH_SPAD  read address, 0..KK-1
//   r_data_spad    out DATA_BITWIDTH  read data, registered
//   r_valid_spad   out 1     r_data_spad valid (1 cycle after read_req_spad)
//   wght_loaded    out 1     level: all KK words written
//   load_done      out 1     1-cycle pulse on the cycle wght_loaded first rises
//   overflow_err   out 1     sticky: write strobe received while FULL
// BEHAVIOUR
//   Reset (async) values:
//     - All outputs = 0; state = EMPTY; w_ptr = 0.
//     - Storage array is NOT reset; reading it before any load is don't-care data.
//   FSM, all transitions on posedge clk; spad_clear has priority over everything:
//     EMPTY  : load_en -> mem[0]<=data, w_ptr<=1, go LOADING (KK==1: go FULL directly).
//     LOADING: load_en -> mem[w_ptr]<=data, w_ptr++.
//              - On the write with w_ptr==KK-1: go FULL, w_ptr<=0.
//              - No load_en: hold. Gaps between beats are legal.
//     FULL   : load_en -> word dropped (no mem write), overflow_err<=1.
//     Any state, spad_clear=1:
//       - go EMPTY, w_ptr<=0, overflow_err<=0, wght_loaded<=0.
//       - A same-cycle load_en beat is dropped; clear wins.
//   Status outputs:
//     - wght_loaded = registered (state==FULL).
//     - load_done rises in the same cycle as wght_loaded and lasts exactly 1 cycle.
//     - A router stream of KK consecutive beats starting at cycle t gives
//       wght_loaded=1 / load_done=1 at cycle t+KK.
//   Read port:
//     - read_req at cycle t -> r_data_spad = mem[r_addr] and r_valid_spad=1 at cycle t+1.
//     - Otherwise r_valid_spad=0 and r_data_spad holds its last value.
//     - Reads are allowed in any state. The MAC is responsible for waiting for wght_loaded.
//     - r_addr >= KK -> r_data_spad = 0, r_valid_spad still = 1.
//     - Read and write to the same address in the same cycle -> read returns the OLD
//       word (read-before-write).
//   Reset mid-load:
//     - Aborts immediately: EMPTY, w_ptr=0.
//     - Words already written stay in the array but are not reported as loaded.
//   Width: w_ptr is clog2(KK) bits (min 1) and wraps to 0 only on the FULL transition.
//   No arithmetic on data; words are stored and returned bit-exact.
// TESTING (kernel_size=3, KK=9)
//   1. Reset, then 9 back-to-back beats of data 0x0011..0x0019
//      -> load_done 1-cycle pulse 9 cycles after the first beat; wght_loaded=1;
//      reading addr 0..8 returns 0x0011..0x0019, each 1 cycle after its request.
//   2. The 9 beats with 2-cycle gaps between them
//      -> same contents; wght_loaded rises only after the 9th beat.
//   3. After FULL, 1 extra beat 0xBEEF
//      -> overflow_err=1 and stays 1; addr 0 still reads 0x0011.
//      Then spad_clear -> overflow_err=0, wght_loaded=0.
//   4. spad_clear and load_en together at beat 5, then 9 fresh beats 0x0100..0x0108
//      -> pad fills from addr 0; reading addr 4 returns 0x0104.
//   5. Async reset asserted mid-clock after beat 4
//      -> outputs 0 immediately; a following full 9-beat load completes normally.
//   6. Read addr 3 in the same cycle as the write of 0x00AA to addr 3 during reload
//      -> old word returned; the next read of addr 3 returns 0x00AA. Read addr 12 -> 0.

Source files
------------

// File: rtl/spad_weight_pe.sv
// Per-PE weight scratchpad: captures one kernel_size**2-word filter from the router
// and serves the MAC through a registered, 1-cycle-latency read port.
module spad_weight_pe #(
  parameter int DATA_BITWIDTH      = 16,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int kernel_size        = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITWIDTH-1:0]      w_data_spad,
  input  logic                          load_en_spad,
  input  logic                          spad_clear,
  input  logic                          read_req_spad,
  input  logic [ADDR_BITWIDTH_SPAD-1:0] r_addr_spad,
  output logic [DATA_BITWIDTH-1:0]      r_data_spad,
  output logic                          r_valid_spad,
  output logic                          wght_loaded,
  output logic                          load_done,
  output logic                          overflow_err,
  output logic [1:0]                    fsm_state
);

  localparam int KK    = kernel_size * kernel_size;
  localparam int PTR_W = (KK > 1) ? $clog2(KK) : 1;
  localparam logic [PTR_W-1:0]              LAST_PTR = PTR_W'(KK - 1);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] KK_ADDR  = ADDR_BITWIDTH_SPAD'(KK);

  // Handshake: load_en_spad is a one-word-per-cycle strobe with no backpressure;
  // read_req_spad is answered unconditionally by r_valid_spad one cycle later.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   w_ptr_q, w_ptr_d;
  logic               mem_we;
  logic               ovf_d;
  logic [DATA_BITWIDTH-1:0] mem [KK];

  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    w_ptr_d = w_ptr_q;
    mem_we  = 1'b0;
    ovf_d   = overflow_err;
    if (spad_clear) begin
      // Clear wins over a same-cycle beat, which is dropped.
      state_d = EMPTY;
      w_ptr_d = '0;
      ovf_d   = 1'b0;
    end else if (load_en_spad) begin
      case (state_q)
        EMPTY: begin
          mem_we = 1'b1;
          if (KK == 1) begin
            state_d = FULL;
          end else begin
            state_d = LOADING;
            w_ptr_d = PTR_W'(1);
          end
        end
        LOADING: begin
          mem_we = 1'b1;
          if (w_ptr_q == LAST_PTR) begin
            state_d = FULL;
            w_ptr_d = '0;
          end else begin
            w_ptr_d = w_ptr_q + 1'b1;
          end
        end
        FULL:    ovf_d   = 1'b1;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      w_ptr_q      <= '0;
      wght_loaded  <= 1'b0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
      r_valid_spad <= 1'b0;
      r_data_spad  <= '0;
    end else begin
      state_q      <= state_d;
      w_ptr_q      <= w_ptr_d;
      overflow_err <= ovf_d;
      // Status tracks the state being entered so the flag lands with the last beat.
      wght_loaded  <= (state_d == FULL);
      load_done    <= (state_d == FULL) && (state_q != FULL);
      r_valid_spad <= read_req_spad;
      if (read_req_spad) begin
        r_data_spad <= (r_addr_spad < KK_ADDR) ? mem[r_addr_spad[PTR_W-1:0]] : '0;
      end
    end
  end

  // Storage is deliberately not reset; a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[w_ptr_q] <= w_data_spad;
    end
  end

endmodule

// File: tb/tb_spad_weight_pe.sv
// Directed bench for spad_weight_pe: a word-count model of the pad checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_spad_weight_pe;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int KK = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] w_data_spad;
  logic          load_en_spad;
  logic          spad_clear;
  logic          read_req_spad;
  logic [AW-1:0] r_addr_spad;
  logic [DW-1:0] r_data_spad;
  logic          r_valid_spad;
  logic          wght_loaded;
  logic          load_done;
  logic          overflow_err;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  spad_weight_pe #(
    .DATA_BITWIDTH(DW),
    .ADDR_BITWIDTH_SPAD(AW),
    .kernel_size(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .w_data_spad(w_data_spad),
    .load_en_spad(load_en_spad),
    .spad_clear(spad_clear),
    .read_req_spad(read_req_spad),
    .r_addr_spad(r_addr_spad),
    .r_data_spad(r_data_spad),
    .r_valid_spad(r_valid_spad),
    .wght_loaded(wght_loaded),
    .load_done(load_done),
    .overflow_err(overflow_err),
    .fsm_state(fsm_state)
  );

  int checks   = 0;
  int failures = 0;
  bit tb_go    = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the pad is a list of words filled in arrival order up to KK entries.
  logic [DW-1:0] m_words [KK];
  bit            m_known [KK];
  int            m_count;
  bit            m_full, m_ovf, m_done, m_rvalid, m_rknown;
  logic [DW-1:0] m_rdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count  = 0;
      m_full   = 1'b0;
      m_ovf    = 1'b0;
      m_done   = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_rknown = 1'b1;
    end else begin
      int idx;
      idx      = int'(r_addr_spad);
      m_rvalid = read_req_spad;
      m_done   = 1'b0;
      if (read_req_spad) begin
        if (idx < KK) begin
          m_rdata  = m_words[idx];
          m_rknown = m_known[idx];
        end else begin
          m_rdata  = '0;
          m_rknown = 1'b1;
        end
      end
      if (spad_clear) begin
        m_count = 0;
        m_full  = 1'b0;
        m_ovf   = 1'b0;
      end else if (load_en_spad) begin
        if (m_full) begin
          m_ovf = 1'b1;
        end else begin
          m_words[m_count] = w_data_spad;
          m_known[m_count] = 1'b1;
          m_count++;
          if (m_count == KK) begin
            m_full = 1'b1;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (tb_go) begin
      check1("cyc_r_valid", r_valid_spad, m_rvalid);
      check1("cyc_wght_loaded", wght_loaded, m_full);
      check1("cyc_load_done", load_done, m_done);
      check1("cyc_overflow_err", overflow_err, m_ovf);
      if (m_rknown) check16("cyc_r_data", r_data_spad, m_rdata);
    end
  end

  task automatic drive(input logic ld, input logic [DW-1:0] d, input logic clr,
                       input logic rd, input logic [AW-1:0] a);
    load_en_spad  = ld;
    w_data_spad   = d;
    spad_clear    = clr;
    read_req_spad = rd;
    r_addr_spad   = a;
    @(posedge clk);
    #1;
    load_en_spad  = 1'b0;
    spad_clear    = 1'b0;
    read_req_spad = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    drive(1'b1, d, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_pad();
    drive(1'b0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    drive(1'b0, '0, 1'b0, 1'b1, a);
    @(negedge clk);
    check1({name, "_valid"}, r_valid_spad, 1'b1);
    check16(name, r_data_spad, exp);
  endtask

  initial begin
    reset         = 1'b1;
    w_data_spad   = '0;
    load_en_spad  = 1'b0;
    spad_clear    = 1'b0;
    read_req_spad = 1'b0;
    r_addr_spad   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check1("rst_r_valid", r_valid_spad, 1'b0);
    check16("rst_r_data", r_data_spad, 16'h0000);
    check1("rst_wght_loaded", wght_loaded, 1'b0);
    check1("rst_load_done", load_done, 1'b0);
    check1("rst_overflow", overflow_err, 1'b0);
    tb_go = 1'b1;

    // 1: back-to-back load, done pulse after the 9th beat
    for (int i = 0; i < KK; i++) begin
      beat(16'(16'h0011 + i));
      if (i == 7) begin
        @(negedge clk);
        check1("t1_not_loaded_early", wght_loaded, 1'b0);
      end
    end
    @(negedge clk);
    check1("t1_load_done", load_done, 1'b1);
    check1("t1_wght_loaded", wght_loaded, 1'b1);
    @(negedge clk);
    check1("t1_load_done_1cyc", load_done, 1'b0);
    check1("t1_wght_held", wght_loaded, 1'b1);
    for (int a = 0; a < KK; a++) read_chk(9'(a), 16'(16'h0011 + a), "t1_rd");

    // 2: gapped load of the same data
    clear_pad();
    @(negedge clk);
    check1("t2_cleared", wght_loaded, 1'b0);
    for (int i = 0; i < KK; i++) begin
      beat(16'(16'h0011 + i));
      if (i < KK - 1) begin
        idle(2);
        check1("t2_not_loaded_gap", wght_loaded, 1'b0);
      end
    end
    @(negedge clk);
    check1("t2_load_done", load_done, 1'b1);
    read_chk(9'd0, 16'h0011, "t2_rd0");
    read_chk(9'd4, 16'h0015, "t2_rd4");
    read_chk(9'd8, 16'h0019, "t2_rd8");

    // 3: overflow beat is dropped and sticky until clear
    beat(16'hBEEF);
    @(negedge clk);
    check1("t3_ovf", overflow_err, 1'b1);
    idle(3);
    check1("t3_ovf_sticky", overflow_err, 1'b1);
    read_chk(9'd0, 16'h0011, "t3_rd0");
    clear_pad();
    @(negedge clk);
    check1("t3_ovf_cleared", overflow_err, 1'b0);
    check1("t3_wght_cleared", wght_loaded, 1'b0);

    // 4: clear coincident with beat 5, then a fresh filter
    for (int i = 0; i < 4; i++) beat(16'(16'h0200 + i));
    drive(1'b1, 16'h0204, 1'b1, 1'b0, '0);
    @(negedge clk);
    check1("t4_clear_wins", wght_loaded, 1'b0);
    for (int i = 0; i < KK; i++) beat(16'(16'h0100 + i));
    @(negedge clk);
    check1("t4_load_done", load_done, 1'b1);
    read_chk(9'd4, 16'h0104, "t4_rd4");
    read_chk(9'd0, 16'h0100, "t4_rd0");

    // 5: async reset mid-cycle after beat 4
    clear_pad();
    for (int i = 0; i < 3; i++) beat(16'(16'h0300 + i));
    drive(1'b1, 16'h0303, 1'b0, 1'b1, 9'd0);
    check1("t5_pre_valid", r_valid_spad, 1'b1);
    check16("t5_pre_data", r_data_spad, 16'h0300);
    #2 reset = 1'b1;
    #1;
    check1("t5_rst_valid", r_valid_spad, 1'b0);
    check16("t5_rst_data", r_data_spad, 16'h0000);
    check1("t5_rst_wght", wght_loaded, 1'b0);
    check1("t5_rst_ovf", overflow_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < KK; i++) beat(16'(16'h0400 + i));
    @(negedge clk);
    check1("t5_load_done", load_done, 1'b1);
    read_chk(9'd8, 16'h0408, "t5_rd8");
    read_chk(9'd3, 16'h0403, "t5_rd3");

    // 6: read-before-write on addr 3, then out-of-range read
    clear_pad();
    for (int i = 0; i < 3; i++) beat(16'(16'h0500 + i));
    drive(1'b1, 16'h00AA, 1'b0, 1'b1, 9'd3);
    @(negedge clk);
    check16("t6_old_word", r_data_spad, 16'h0403);
    read_chk(9'd3, 16'h00AA, "t6_new_word");
    read_chk(9'd12, 16'h0000, "t6_oob");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
